// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD feeder: default datapath width and FSM encoding.
package gcd_pkg;

    localparam int GCD_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } gcd_state_e;

endpackage : gcd_pkg

// File: rtl/gcd_fifo.sv
// Operand-pair FIFO with combinational head read (dout always shows the oldest entry).
module gcd_fifo #(
    parameter int W2    = 16,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W2-1:0]                din,
    output logic [W2-1:0]                dout,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W2-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          push_ok_s;
    logic          pop_ok_s;

    // Guard against overflow/underflow even if the caller misbehaves.
    assign push_ok_s = push && (count_q < CW'(DEPTH));
    assign pop_ok_s  = pop && (count_q != {CW{1'b0}});

    // Occupancy update; simultaneous push and pop leave it unchanged.
    always_comb begin
        count_d = count_q;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            count_q <= count_d;
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    // Storage array.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule : gcd_fifo

// File: rtl/gcd_feeder.sv
// Queues operand pairs and feeds them one at a time to an external GCD core,
// short-circuiting pairs with a zero operand and returning results in order.
module gcd_feeder
    import gcd_pkg::*;
#(
    parameter int W     = GCD_W,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [W-1:0]                 in_a,
    input  logic [W-1:0]                 in_b,
    output logic                         core_start,
    output logic [W-1:0]                 core_a,
    output logic [W-1:0]                 core_b,
    input  logic                         core_done,
    input  logic [W-1:0]                 core_result,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [W-1:0]                 out_result,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

    localparam int CW = $clog2(DEPTH+1);

    gcd_state_e    state_q;
    gcd_state_e    state_d;
    logic [2*W-1:0] head_s;
    logic [W-1:0]  head_a_s;
    logic [W-1:0]  head_b_s;
    logic [CW-1:0] count_s;
    logic          push_s;
    logic          pop_s;
    logic          fifo_empty_s;
    logic          slot_free_s;
    logic          head_zero_s;

    logic          core_start_q, core_start_d;
    logic [W-1:0]  core_a_q, core_a_d;
    logic [W-1:0]  core_b_q, core_b_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_result_q, out_result_d;

    gcd_fifo #(
        .W2    (2*W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .din   ({in_a, in_b}),
        .dout  (head_s),
        .count (count_s)
    );

    assign in_ready     = (count_s < CW'(DEPTH));
    assign push_s       = in_valid && in_ready;
    assign fifo_empty_s = (count_s == {CW{1'b0}});
    assign slot_free_s  = !out_valid_q || out_ready;
    assign head_a_s     = head_s[2*W-1:W];
    assign head_b_s     = head_s[W-1:0];
    assign head_zero_s  = (head_a_s == {W{1'b0}}) || (head_b_s == {W{1'b0}});

    // Next-state logic; a pop only happens from IDLE when the result slot can take its answer.
    always_comb begin
        state_d = state_q;
        pop_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s && slot_free_s) begin
                    pop_s = 1'b1;
                    if (head_zero_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (core_done) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output next-values; gcd(x,0) = x, so a zero-operand pair resolves to a|b without the core.
    always_comb begin
        core_start_d = (state_d == ST_ISSUE);
        core_a_d     = core_a_q;
        core_b_d     = core_b_q;
        out_result_d = out_result_q;
        if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        if (pop_s) begin
            core_a_d = head_a_s;
            core_b_d = head_b_s;
            if (head_zero_s) begin
                out_valid_d  = 1'b1;
                out_result_d = head_a_s | head_b_s;
            end else begin
                out_result_d = out_result_q;
            end
        end else if ((state_q == ST_WAIT) && core_done) begin
            out_valid_d  = 1'b1;
            out_result_d = core_result;
        end else begin
            out_result_d = out_result_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            core_start_q <= 1'b0;
            core_a_q     <= {W{1'b0}};
            core_b_q     <= {W{1'b0}};
            out_valid_q  <= 1'b0;
            out_result_q <= {W{1'b0}};
        end else begin
            state_q      <= state_d;
            core_start_q <= core_start_d;
            core_a_q     <= core_a_d;
            core_b_q     <= core_b_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
        end
    end

    assign core_start = core_start_q;
    assign core_a     = core_a_q;
    assign core_b     = core_b_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign busy       = (state_q != ST_IDLE) || !fifo_empty_s;
    assign fifo_count = count_s;

endmodule : gcd_feeder

// File: doc/gcd_feeder.md
GCD_FEEDER -- requirements
Module: gcd_feeder

Interface
REQ-001 SHALL have parameter W, default 8, operand/result width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, operand FIFO entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand pair offered.
REQ-006 SHALL have port in_ready  output  1  FIFO can accept the pair.
REQ-007 SHALL have ports in_a, in_b  input  W  operand pair.
REQ-008 SHALL have port core_start  output  1  one-cycle start pulse to the GCD core.
REQ-009 SHALL have ports core_a, core_b  output  W  operands to the core.
REQ-010 SHALL have port core_done  input  1  core finished; core_result valid this cycle.
REQ-011 SHALL have port core_result  input  W  GCD from the core.
REQ-012 SHALL have port out_valid  output  1  out_result holds a result.
REQ-013 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-014 SHALL have port out_result  output  W  GCD result.
REQ-015 SHALL have port busy  output  1  FSM not in IDLE, or FIFO non-empty.
REQ-016 SHALL have port fifo_count  output  clog2(DEPTH+1)  current FIFO occupancy.

Function
REQ-017 SHALL push {in_a,in_b} when in_valid && in_ready; in_ready = (fifo_count < DEPTH), with no same-cycle pass-through when full.
REQ-018 SHALL leave fifo_count unchanged on simultaneous push and pop; read/write pointers wrap modulo DEPTH.
REQ-019 SHALL implement FSM states IDLE, ISSUE, WAIT.
REQ-020 In IDLE, when FIFO non-empty and slot_free = (!out_valid || out_ready), SHALL pop the head and latch it into core_a/core_b.
REQ-021 On a pop where either operand is 0, SHALL bypass the core: load out_result = a|b, set out_valid next edge, stay in IDLE, no core_start.
REQ-022 On a pop with both operands non-zero, SHALL go to ISSUE.
REQ-023 In ISSUE, core_start SHALL be 1 for exactly one cycle; next state WAIT.
REQ-024 core_a/core_b SHALL hold stable from ISSUE until the edge on which core_done is sampled in WAIT.
REQ-025 In WAIT, on core_done=1, SHALL capture core_result into out_result, set out_valid at that edge, and return to IDLE.
REQ-026 SHALL ignore core_done outside WAIT.
REQ-027 While out_valid && !out_ready, out_result SHALL hold stable; out_valid SHALL clear on out_ready unless refilled on the same edge.
REQ-028 Results SHALL leave in input order; at most one pair SHALL be in flight in the core.

Reset
REQ-029 reset low SHALL immediately clear FSM to IDLE, FIFO pointers and fifo_count to 0, and core_start, out_valid, out_result, core_a, core_b to 0; in_ready=1 and busy=0 while held.
REQ-030 A reset asserted mid-WAIT SHALL discard the in-flight pair; the GCD core shares the same reset.

Structure
REQ-031 FSM state encodings and the default W SHALL live in shared package gcd_pkg.
REQ-032 The FIFO SHALL be a separate sub-module gcd_fifo (parameters W2=2*W, DEPTH; ports clk, reset, push, pop, din, dout, count).

Verification
REQ-033 Push (48,18), core model done after 5 cycles with result 6 -> one core_start, out_result=6, out_valid 1 cycle after core_done.
REQ-034 Push (0,35), then (0,0) -> no core_start; out_result=35, then 0; each out_valid 1 cycle after its pop.
REQ-035 out_ready=0; push 6 pairs back-to-back -> first completes to out_result; fifo_count reaches 4; in_ready=0 for pair 6 until a pop; drain order matches input.
REQ-036 Hold out_ready=0 for 10 cycles after out_valid -> out_result stable, no new core_start; release -> next pair issued the same cycle.
REQ-037 Assert reset in WAIT with 2 pairs queued -> all outputs at reset values, fifo_count=0; a late core_done after reset is ignored.
REQ-038 Push on the same edge as a pop at fifo_count=3 -> fifo_count stays 3; pointers wrap correctly over 10 transactions.
